// File: rtl/instruction_fetch_unit.sv
// Multi-cycle fetch stage: owns the PC, fetches one word over req/ack, holds it for
// decode/execute, then resolves the next PC from the branch code and FU flags.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned IMEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic        inst_valid,
    input  logic        exec_done,
    input  logic [3:0]  Branch_Control,
    input  logic [31:0] imm,
    input  logic [31:0] rs1_data,
    input  logic        flag_z,
    input  logic        flag_n,
    input  logic        flag_c,
    input  logic        flag_v,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fault,
    output logic [1:0]  fault_code,
    output logic [31:0] instret
);

    typedef enum logic [1:0] {StFetch, StIssue, StHalt} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] instret_q, instret_d;
    logic        fault_q, fault_d;
    logic [1:0]  fault_code_q, fault_code_d;
    logic [15:0] wait_q, wait_d;
    logic [16:0] wait_inc;
    logic [31:0] next_pc, taken_pc, jalr_pc;
    logic        taken;

    assign pc_plus4 = pc_q + 32'd4;
    assign taken_pc = pc_q + imm;
    assign jalr_pc  = (rs1_data + imm) & ~32'h1;
    assign wait_inc = {1'b0, wait_q} + 17'd1;

    always_comb begin
        taken   = 1'b0;
        next_pc = pc_plus4;
        case (Branch_Control)
            4'd1:    next_pc = taken_pc;
            4'd2:    next_pc = jalr_pc;
            4'd3:    taken = flag_n ^ flag_v;
            4'd4:    taken = ~(flag_n ^ flag_v);
            4'd5:    taken = flag_z;
            4'd6:    taken = ~flag_z;
            4'd7:    taken = ~flag_c;
            4'd8:    taken = flag_c;
            default: next_pc = pc_plus4;
        endcase
        if (taken) begin
            next_pc = taken_pc;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        instret_d    = instret_q;
        fault_d      = fault_q;
        fault_code_d = fault_code_q;
        wait_d       = wait_q;
        unique case (state_q)
            StFetch: begin
                if (imem_ack) begin
                    inst_d  = imem_rdata;
                    wait_d  = 16'd0;
                    state_d = StIssue;
                end else begin
                    wait_d = wait_inc[15:0];
                    if (wait_inc == 17'(IMEM_TIMEOUT)) begin
                        fault_d      = 1'b1;
                        fault_code_d = 2'b01;
                        state_d      = StHalt;
                    end
                end
            end
            StIssue: begin
                if (exec_done) begin
                    // A misaligned target faults before anything architectural changes.
                    if (next_pc[1:0] != 2'b00) begin
                        fault_d      = 1'b1;
                        fault_code_d = 2'b10;
                        state_d      = StHalt;
                    end else begin
                        pc_d      = next_pc;
                        instret_d = instret_q + 32'd1;
                        state_d   = StFetch;
                    end
                end
            end
            StHalt:  state_d = StHalt;
            default: state_d = StHalt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StFetch;
            pc_q         <= RESET_PC;
            inst_q       <= 32'd0;
            instret_q    <= 32'd0;
            fault_q      <= 1'b0;
            fault_code_q <= 2'b00;
            wait_q       <= 16'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            instret_q    <= instret_d;
            fault_q      <= fault_d;
            fault_code_q <= fault_code_d;
            wait_q       <= wait_d;
        end
    end

    // Request is masked while rst is held so it only rises once reset deasserts.
    assign imem_req   = (state_q == StFetch) && !rst;
    assign imem_addr  = pc_q;
    assign inst       = inst_q;
    assign inst_valid = (state_q == StIssue);
    assign pc         = pc_q;
    assign fault      = fault_q;
    assign fault_code = fault_code_q;
    assign instret    = instret_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus randomized programs checked
// against a next-PC model built from the branch-code rules.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] inst;
    logic        inst_valid;
    logic        exec_done = 1'b0;
    logic [3:0]  Branch_Control = 4'd0;
    logic [31:0] imm = 32'd0;
    logic [31:0] rs1_data = 32'd0;
    logic        flag_z = 1'b0, flag_n = 1'b0, flag_c = 1'b0, flag_v = 1'b0;
    logic [31:0] pc, pc_plus4, instret;
    logic        fault;
    logic [1:0]  fault_code;

    int total = 0;
    int bad   = 0;

    instruction_fetch_unit #(
        .RESET_PC    (32'h0000_0000),
        .IMEM_TIMEOUT(4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .inst          (inst),
        .inst_valid    (inst_valid),
        .exec_done     (exec_done),
        .Branch_Control(Branch_Control),
        .imm           (imm),
        .rs1_data      (rs1_data),
        .flag_z        (flag_z),
        .flag_n        (flag_n),
        .flag_c        (flag_c),
        .flag_v        (flag_v),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .fault         (fault),
        .fault_code    (fault_code),
        .instret       (instret)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_next(input logic [31:0] p, input logic [3:0] code,
                                               input logic [31:0] im, input logic [31:0] r1,
                                               input logic z, input logic n, input logic c,
                                               input logic v);
        logic t;
        t = 1'b0;
        if (code == 4'd1) return p + im;
        if (code == 4'd2) return (r1 + im) & 32'hFFFF_FFFE;
        if (code == 4'd3) t = (n != v);
        if (code == 4'd4) t = (n == v);
        if (code == 4'd5) t = z;
        if (code == 4'd6) t = !z;
        if (code == 4'd7) t = !c;
        if (code == 4'd8) t = c;
        return t ? p + im : p + 32'd4;
    endfunction

    // One instruction with same-cycle ack and same-cycle exec_done.
    task automatic do_inst(input logic [3:0] code, input logic [31:0] im,
                           input logic [31:0] r1, input logic [3:0] flags);
        imem_ack   = 1'b1;
        imem_rdata = $urandom;
        step();
        imem_ack       = 1'b0;
        exec_done      = 1'b1;
        Branch_Control = code;
        imm            = im;
        rs1_data       = r1;
        {flag_z, flag_n, flag_c, flag_v} = flags;
        step();
        exec_done = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        imem_ack  = 1'b0;
        exec_done = 1'b0;
        step();
        step();
        total++;
        if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", imem_req); end
        total++;
        if ({pc, inst, instret} !== 96'd0) begin
            bad++; $display("FAIL reset_regs pc=%h inst=%h instret=%h exp=0", pc, inst, instret);
        end
        total++;
        if ({inst_valid, fault, fault_code} !== 4'd0) begin
            bad++; $display("FAIL reset_flags valid=%b fault=%b code=%b exp=0", inst_valid, fault,
                            fault_code);
        end
        rst = 1'b0;
        #1;
        total++;
        if (imem_req !== 1'b1) begin bad++; $display("FAIL reset_req_rise got=%b exp=1", imem_req); end
    endtask

    task automatic test_sequential();
        test_reset();
        imem_ack       = 1'b1;
        exec_done      = 1'b1;
        Branch_Control = 4'd0;
        for (int c = 0; c < 8; c++) begin
            if (c % 2 == 0) begin
                total++;
                if (imem_req !== 1'b1 || imem_addr !== 32'(4 * (c / 2)) ||
                    instret !== 32'(c / 2)) begin
                    bad++;
                    $display("FAIL seq_fetch c=%0d req=%b addr=%h instret=%0d exp addr=%h instret=%0d",
                             c, imem_req, imem_addr, instret, 4 * (c / 2), c / 2);
                end
            end else begin
                total++;
                if (inst_valid !== 1'b1) begin
                    bad++; $display("FAIL seq_issue c=%0d valid=%b exp=1", c, inst_valid);
                end
            end
            step();
        end
        imem_ack  = 1'b0;
        exec_done = 1'b0;
    endtask

    task automatic test_beq();
        test_reset();
        do_inst(4'd1, 32'h100, 32'd0, 4'b0000);
        do_inst(4'd5, 32'hFFFF_FFF0, 32'd0, 4'b1000);
        total++;
        if (imem_addr !== 32'hF0) begin bad++; $display("FAIL beq_taken got=%h exp=f0", imem_addr); end
        do_inst(4'd1, 32'h10, 32'd0, 4'b0000);
        do_inst(4'd5, 32'hFFFF_FFF0, 32'd0, 4'b0000);
        total++;
        if (imem_addr !== 32'h104) begin bad++; $display("FAIL beq_not got=%h exp=104", imem_addr); end
    endtask

    task automatic test_jalr();
        test_reset();
        do_inst(4'd2, 32'h10, 32'h2001, 4'b0000);
        total++;
        if (imem_addr !== 32'h2010) begin bad++; $display("FAIL jalr got=%h exp=2010", imem_addr); end
        do_inst(4'd2, 32'h0, 32'h2002, 4'b0000);
        step();
        total++;
        if (fault !== 1'b1 || fault_code !== 2'b10) begin
            bad++; $display("FAIL jalr_misalign fault=%b code=%b exp=1/10", fault, fault_code);
        end
        total++;
        if (pc !== 32'h2010 || imem_req !== 1'b0 || instret !== 32'd1) begin
            bad++; $display("FAIL jalr_frozen pc=%h req=%b instret=%0d exp=2010/0/1", pc, imem_req,
                            instret);
        end
    endtask

    task automatic test_timeout();
        test_reset();
        for (int i = 0; i < 3; i++) step();
        total++;
        if (fault !== 1'b0) begin bad++; $display("FAIL timeout_early fault=%b exp=0", fault); end
        step();
        total++;
        if (fault !== 1'b1 || fault_code !== 2'b01 || imem_req !== 1'b0) begin
            bad++; $display("FAIL timeout fault=%b code=%b req=%b exp=1/01/0", fault, fault_code,
                            imem_req);
        end
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_ack = 1'b0;
        step();
        total++;
        if (inst_valid !== 1'b0 || inst !== 32'd0 || fault_code !== 2'b01) begin
            bad++; $display("FAIL halt_ack valid=%b inst=%h code=%b exp=0/0/01", inst_valid, inst,
                            fault_code);
        end
        test_reset();
        total++;
        if (pc !== 32'd0 || fault !== 1'b0) begin
            bad++; $display("FAIL timeout_reset pc=%h fault=%b exp=0/0", pc, fault);
        end
    endtask

    task automatic test_cond();
        test_reset();
        do_inst(4'd1, 32'h40, 32'd0, 4'b0000);
        do_inst(4'd7, 32'h8, 32'd0, 4'b0000);
        total++;
        if (imem_addr !== 32'h48) begin bad++; $display("FAIL bltu got=%h exp=48", imem_addr); end
        do_inst(4'd1, 32'hFFFF_FFF8, 32'd0, 4'b0000);
        do_inst(4'd4, 32'h8, 32'd0, 4'b0101);
        total++;
        if (imem_addr !== 32'h48) begin bad++; $display("FAIL bge got=%h exp=48", imem_addr); end
        do_inst(4'd1, 32'hFFFF_FFF8, 32'd0, 4'b0000);
        do_inst(4'd12, 32'h8, 32'd0, 4'b1111);
        total++;
        if (imem_addr !== 32'h44) begin bad++; $display("FAIL code12 got=%h exp=44", imem_addr); end
    endtask

    task automatic test_reset_issue();
        test_reset();
        exec_done = 1'b1;
        step();
        exec_done = 1'b0;
        total++;
        if (imem_req !== 1'b1 || inst_valid !== 1'b0 || pc !== 32'd0) begin
            bad++; $display("FAIL spurious_exec req=%b valid=%b pc=%h exp=1/0/0", imem_req,
                            inst_valid, pc);
        end
        do_inst(4'd0, 32'd0, 32'd0, 4'b0000);
        imem_ack = 1'b1;
        step();
        imem_ack       = 1'b0;
        exec_done      = 1'b1;
        Branch_Control = 4'd0;
        rst            = 1'b1;
        step();
        exec_done = 1'b0;
        rst       = 1'b0;
        #1;
        total++;
        if (pc !== 32'd0 || instret !== 32'd0 || inst_valid !== 1'b0) begin
            bad++; $display("FAIL reset_in_issue pc=%h instret=%0d valid=%b exp=0/0/0", pc, instret,
                            inst_valid);
        end
    endtask

    task automatic test_random();
        logic [31:0] mpc, mret, word, im, r1, exp_pc;
        logic [3:0]  code, fl;
        test_reset();
        mpc  = 32'd0;
        mret = 32'd0;
        for (int n = 0; n < 60; n++) begin
            for (int k = $urandom_range(0, 2); k > 0; k--) begin
                exec_done = 1'($urandom_range(0, 1));
                step();
            end
            total++;
            if (imem_req !== 1'b1 || imem_addr !== mpc || instret !== mret) begin
                bad++; $display("FAIL rnd_fetch n=%0d req=%b addr=%h instret=%0d exp addr=%h ret=%0d",
                                n, imem_req, imem_addr, instret, mpc, mret);
            end
            word       = $urandom;
            imem_ack   = 1'b1;
            imem_rdata = word;
            exec_done  = 1'($urandom_range(0, 1));
            step();
            imem_ack  = 1'b0;
            exec_done = 1'b0;
            for (int j = $urandom_range(0, 3); j > 0; j--) begin
                imem_ack   = 1'($urandom_range(0, 1));
                imem_rdata = $urandom;
                step();
            end
            imem_ack = 1'b0;
            total++;
            if (inst_valid !== 1'b1 || inst !== word || pc !== mpc) begin
                bad++; $display("FAIL rnd_issue n=%0d valid=%b inst=%h pc=%h exp inst=%h pc=%h", n,
                                inst_valid, inst, pc, word, mpc);
            end
            code = 4'($urandom_range(0, 15));
            im   = $urandom & 32'hFFFF_FFFC;
            r1   = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(0, 1));
            fl   = 4'($urandom_range(0, 15));
            exp_pc = model_next(mpc, code, im, r1, fl[3], fl[2], fl[1], fl[0]);
            exec_done      = 1'b1;
            Branch_Control = code;
            imm            = im;
            rs1_data       = r1;
            {flag_z, flag_n, flag_c, flag_v} = fl;
            total++;
            if (pc_plus4 !== mpc + 32'd4) begin
                bad++; $display("FAIL rnd_pc_plus4 got=%h exp=%h", pc_plus4, mpc + 32'd4);
            end
            step();
            exec_done = 1'b0;
            mpc  = exp_pc;
            mret = mret + 32'd1;
        end
        total++;
        if (fault !== 1'b0 || imem_addr !== mpc) begin
            bad++; $display("FAIL rnd_end fault=%b addr=%h exp=0/%h", fault, imem_addr, mpc);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_beq();
        test_jalr();
        test_timeout();
        test_cond();
        test_reset_issue();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Multi-cycle fetch stage directly upstream of the instruction decoder.
- Owns the program counter and fetches one 32-bit instruction at a time from instruction memory over a req/ack handshake.
- Presents the instruction to the decoder, then waits for the datapath to finish executing it.
- Resolves the next PC from the decoder's Branch_Control code, the FU flags, the immediate and rs1. Faults halt the unit until reset.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_TIMEOUT, 255, max FETCH cycles without imem_ack before fault (1..65535).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- imem_req  out  1  fetch request, high for the whole FETCH state
- imem_addr  out  32  byte address, equals pc
- imem_ack  in  1  imem_rdata valid this cycle
- imem_rdata  in  32  fetched instruction word
- inst  out  32  instruction to decoder
- inst_valid  out  1  inst held stable for decode/execute
- exec_done  in  1  datapath finished inst; branch inputs valid this cycle
- Branch_Control  in  4  decoder next-PC code
- imm  in  32  sign-extended immediate
- rs1_data  in  32  register rs1 value (JALR base)
- flag_z, flag_n, flag_c, flag_v  in  1 each  FU flags from rs1-rs2 compare; C = carry of A+~B+1
- pc  out  32  address of current instruction
- pc_plus4  out  32  pc+4 (JAL/JALR link value)
- fault  out  1  sticky fault
- fault_code  out  2  01 = imem timeout, 10 = misaligned target
- instret  out  32  retired-instruction counter

Behaviour:
- Reset (rst high at clk edge, any state, including mid-fetch or mid-issue):
  - pc=RESET_PC, state=FETCH, inst=0, inst_valid=0, fault=0, fault_code=00, instret=0, wait counter=0.
  - imem_req is 0 during the reset cycle and rises the first cycle after rst deasserts.
- States: FETCH, ISSUE, HALT. imem_req=1 only in FETCH. inst_valid=1 only in ISSUE.
- FETCH:
  - imem_addr=pc, and it is held stable.
  - imem_ack=1 this cycle: inst<=imem_rdata, wait counter<=0, next state ISSUE.
  - Otherwise the wait counter increments. When it reaches IMEM_TIMEOUT: fault<=1, fault_code<=01, next state HALT.
- ISSUE:
  - inst and pc are held stable.
  - exec_done=1: compute next_pc and check it.
    - If next_pc[1:0]!=00: fault<=1, fault_code<=10, HALT. pc is unchanged and instret does not increment.
    - Otherwise: pc<=next_pc, instret<=instret+1, inst_valid<=0, next state FETCH.
  - exec_done=0: stay in ISSUE indefinitely. There is no timeout.
- HALT: all outputs frozen, imem_req=0, inst_valid=0. Exit only via rst.
- imem_ack outside FETCH and exec_done outside ISSUE are ignored.
- next_pc by Branch_Control:
  - 0: pc+4
  - 1: pc+imm
  - 2: (rs1_data+imm) & ~1
  - 3 BLT: taken if n^v
  - 4 BGE: taken if !(n^v)
  - 5 BEQ: taken if z
  - 6 BNE: taken if !z
  - 7 BLTU: taken if !c
  - 8 BGEU: taken if c
  - 9..15: pc+4
  - Conditional codes 3..8 give pc+imm when taken, else pc+4.
- Arithmetic: all adds are 32-bit modulo and wrap silently; 32'hFFFF_FFFC+4 gives 0. instret wraps at 2^32.
- pc_plus4 = pc+4 combinationally, valid in all states.
- Latency:
  - Minimum 2 cycles per instruction: FETCH with same-cycle ack, then ISSUE with same-cycle exec_done.
  - inst_valid rises 1 cycle after the accepting ack.
  - imem_req rises 1 cycle after the accepting exec_done.

Test Plan:
- Reset, imem_ack always 1, exec_done always 1, Branch_Control=0 -> imem_addr sequence 0,4,8,12, one instruction every 2 cycles; instret=3 when addr=12.
- pc=0x100, BEQ code 5, imm=0xFFFFFFF0, flag_z=1 -> next imem_addr=0xF0; same case with flag_z=0 -> 0x104.
- JALR code 2, rs1_data=0x2001, imm=0x10 -> next pc=0x2010 (bit0 cleared); rs1_data=0x2002, imm=0 -> fault=1, fault_code=10, pc stays, imem_req stays 0.
- IMEM_TIMEOUT=4, imem_ack held 0 -> fault=1, fault_code=01 after 4 FETCH cycles; later imem_ack pulse has no effect; rst -> pc=RESET_PC, fault=0.
- BLTU code 7 with c=0 and BGE code 4 with n=1, v=1, imm=8, pc=0x40 -> both next pc=0x48; code 12 -> pc=0x44.
- rst asserted in ISSUE while exec_done=1 -> pc=RESET_PC, instret=0, inst_valid=0, no retire counted; spurious exec_done during FETCH -> ignored.
